reg_file_sb: RTL and testbench

- Parametrised successor to the core register file.
- Adds a second write port, a third read port, configurable width and depth, and a hardwired-zero address range.
- Adds a pending-write scoreboard that flags read-after-write hazards to the hazard unit.
- Sits between decode (reads, issue) and writeback (ALU result on port 0, memory/late result on port 1).

---
 rtl/reg_file_sb.sv | 144 ++++++++++++++
 tb/tb_reg_file_sb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - three-read/two-write register file with pending-write scoreboard
//
// Purpose:
//   NUM_REGS x DATA_W register file for decode/writeback. Write port 0 carries
//   ALU results and write port 1 carries load/late results; on a same-address
//   collision port 1 wins. Three combinational read ports. A per-register busy
//   bit is set on issue and cleared on writeback; stall flags a used source
//   whose producer has not yet written back.
//   Indices NUM_REGS..2^ADDR_W-1 are unimplemented: they read 0, ignore writes
//   and issues, and never stall.
//
// Optional feature macro: RF_BYPASS_EN
//   When defined, each read port forwards same-cycle write data (port 1 over
//   port 0), and a forwarded source does not stall.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   wr0_en/wr0_addr/wr0_data    write port 0 (ALU writeback)
//   wr1_en/wr1_addr/wr1_data    write port 1 (load writeback)
//   rd_addrN/rd_useN/rd_dataN   read ports N = 1..3 (use = source consumed)
//   issue_en/issue_dest         destination of the issuing instruction
//   busy_vec                    per-register pending-write flags
//   stall                       a used source is pending
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr0_en,
    input  logic [ADDR_W-1:0]      wr0_addr,
    input  logic [DATA_W-1:0]      wr0_data,
    input  logic                   wr1_en,
    input  logic [ADDR_W-1:0]      wr1_addr,
    input  logic [DATA_W-1:0]      wr1_data,
    input  logic [ADDR_W-1:0]      rd_addr1,
    input  logic [ADDR_W-1:0]      rd_addr2,
    input  logic [ADDR_W-1:0]      rd_addr3,
    input  logic                   rd_use1,
    input  logic                   rd_use2,
    input  logic                   rd_use3,
    output logic [DATA_W-1:0]      rd_data1,
    output logic [DATA_W-1:0]      rd_data2,
    output logic [DATA_W-1:0]      rd_data3,
    input  logic                   issue_en,
    input  logic [ADDR_W-1:0]      issue_dest,
    output logic [(1<<ADDR_W)-1:0] busy_vec,
    output logic                   stall
);

    localparam int DEPTH = 1 << ADDR_W;

    // Full-depth view of the storage; unimplemented entries are tied to zero
    // so reads can index it with any address.
    logic [DATA_W-1:0] w_rf [DEPTH];
    logic [DEPTH-1:0]  w_busy;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_reg
            if (g < NUM_REGS) begin : g_impl
                logic [DATA_W-1:0] r_data;
                logic              r_busy;
                logic              w_hit0;
                logic              w_hit1;
                logic              w_set;

                assign w_hit0 = wr0_en && (wr0_addr == ADDR_W'(g));
                assign w_hit1 = wr1_en && (wr1_addr == ADDR_W'(g));
                assign w_set  = issue_en && (issue_dest == ADDR_W'(g));

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_data <= '0;
                    end else if (w_hit1) begin
                        r_data <= wr1_data;
                    end else if (w_hit0) begin
                        r_data <= wr0_data;
                    end
                end

                // A new producer issuing in the same cycle as the old one
                // writes back keeps the register pending.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_busy <= 1'b0;
                    end else if (w_set) begin
                        r_busy <= 1'b1;
                    end else if (w_hit0 || w_hit1) begin
                        r_busy <= 1'b0;
                    end
                end

                assign w_rf[g]   = r_data;
                assign w_busy[g] = r_busy;
            end else begin : g_unimpl
                assign w_rf[g]   = '0;
                assign w_busy[g] = 1'b0;
            end
        end
    endgenerate

    logic [ADDR_W-1:0] w_rd_addr [3];
    logic [2:0]        w_rd_use;
    logic [DATA_W-1:0] w_rd_data [3];
    logic [2:0]        w_stall;

    assign w_rd_addr[0] = rd_addr1;
    assign w_rd_addr[1] = rd_addr2;
    assign w_rd_addr[2] = rd_addr3;
    assign w_rd_use     = {rd_use3, rd_use2, rd_use1};

    generate
        for (g = 0; g < 3; g++) begin : g_rd
`ifdef RF_BYPASS_EN
            logic w_impl;
            logic w_byp0;
            logic w_byp1;

            // Widen by one bit so NUM_REGS == 2^ADDR_W compares correctly.
            assign w_impl = ({1'b0, w_rd_addr[g]} < (ADDR_W+1)'(NUM_REGS));
            assign w_byp0 = w_impl && wr0_en && (wr0_addr == w_rd_addr[g]);
            assign w_byp1 = w_impl && wr1_en && (wr1_addr == w_rd_addr[g]);

            assign w_rd_data[g] = w_byp1 ? wr1_data :
                                  w_byp0 ? wr0_data : w_rf[w_rd_addr[g]];
            assign w_stall[g]   = w_rd_use[g] && w_busy[w_rd_addr[g]]
                                  && !(w_byp0 || w_byp1);
`else
            assign w_rd_data[g] = w_rf[w_rd_addr[g]];
            assign w_stall[g]   = w_rd_use[g] && w_busy[w_rd_addr[g]];
`endif
        end
    endgenerate

    // Gate with rst_n so combinational forwarding cannot leak during reset.
    assign rd_data1 = rst_n ? w_rd_data[0] : '0;
    assign rd_data2 = rst_n ? w_rd_data[1] : '0;
    assign rd_data3 = rst_n ? w_rd_data[2] : '0;
    assign busy_vec = w_busy;
    assign stall    = rst_n && (|w_stall);

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed self-checking bench for reg_file_sb
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr0_en, wr1_en;
    logic [3:0]  wr0_addr, wr1_addr;
    logic [31:0] wr0_data, wr1_data;
    logic [3:0]  rd_addr1, rd_addr2, rd_addr3;
    logic        rd_use1, rd_use2, rd_use3;
    logic [31:0] rd_data1, rd_data2, rd_data3;
    logic        issue_en;
    logic [3:0]  issue_dest;
    logic [15:0] busy_vec;
    logic        stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
        .rd_use1(rd_use1), .rd_use2(rd_use2), .rd_use3(rd_use3),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3),
        .issue_en(issue_en), .issue_dest(issue_dest),
        .busy_vec(busy_vec), .stall(stall)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr0_en = 0; wr0_addr = 0; wr0_data = 0;
        wr1_en = 0; wr1_addr = 0; wr1_data = 0;
        rd_use1 = 0; rd_use2 = 0; rd_use3 = 0;
        issue_en = 0; issue_dest = 0;
    endtask

    // Commit on the next rising edge, then settle 1 time unit past it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0;
        idle();
        rd_addr1 = 0; rd_addr2 = 0; rd_addr3 = 0;
        cyc(); cyc();
        check("reset_busy", busy_vec, 16'h0000);
        check("reset_stall", stall, 1'b0);
        check("reset_rd1", rd_data1, 32'h0);
        rst_n = 1;
        cyc();

        // r3 <= DEADBEEF, issue r2, then asynchronous reset mid-cycle
        wr0_en = 1; wr0_addr = 3; wr0_data = 32'hDEADBEEF;
        issue_en = 1; issue_dest = 2;
        cyc();
        idle();
        rd_addr1 = 3;
        #1;
        check("pre_reset_r3", rd_data1, 32'hDEADBEEF);
        check("pre_reset_busy", busy_vec, 16'h0004);
        wr0_en = 1; wr0_addr = 3; wr0_data = 32'h11111111;
        issue_en = 1; issue_dest = 5;
        #1 rst_n = 0;
        #1;
        check("async_reset_r3", rd_data1, 32'h0);
        check("async_reset_busy", busy_vec, 16'h0000);
        cyc();
        idle();
        rst_n = 1;
        #1;
        check("reset_discard_wr", rd_data1, 32'h0);
        check("reset_discard_issue", busy_vec, 16'h0000);

        // basic write/read and the unimplemented address
        wr0_en = 1; wr0_addr = 5; wr0_data = 32'h12345678;
        cyc();
        idle();
        rd_addr2 = 5;
        #1 check("read_r5", rd_data2, 32'h12345678);
        wr0_en = 1; wr0_addr = 15; wr0_data = 32'hFFFFFFFF;
        rd_addr3 = 15;
        #1 check("read_a15_during_wr", rd_data3, 32'h0);
        cyc();
        idle();
        #1 check("read_a15_after_wr", rd_data3, 32'h0);

        // write conflict: port 1 wins
        wr0_en = 1; wr0_addr = 7; wr0_data = 32'hAAAA0000;
        wr1_en = 1; wr1_addr = 7; wr1_data = 32'h0000BBBB;
        cyc();
        idle();
        rd_addr1 = 7;
        #1 check("conflict_r7", rd_data1, 32'h0000BBBB);

        // scoreboard hazard on r4
        issue_en = 1; issue_dest = 4;
        cyc();
        idle();
        rd_addr1 = 4; rd_use1 = 1;
        #1;
        check("hazard_stall", stall, 1'b1);
        check("hazard_busy4", busy_vec[4], 1'b1);
        rd_use1 = 0;
        #1 check("hazard_unused", stall, 1'b0);
        wr1_en = 1; wr1_addr = 4; wr1_data = 32'h00000044;
        cyc();
        idle();
        rd_use1 = 1;
        #1;
        check("cleared_busy4", busy_vec[4], 1'b0);
        check("cleared_stall", stall, 1'b0);
        check("cleared_data4", rd_data1, 32'h00000044);

        // issue to an unimplemented address is ignored
        issue_en = 1; issue_dest = 15;
        cyc();
        idle();
        rd_addr2 = 15; rd_use2 = 1;
        #1;
        check("unimpl_busy", busy_vec, 16'h0000);
        check("unimpl_stall", stall, 1'b0);
        idle();

        // set wins over a same-cycle clear
        issue_en = 1; issue_dest = 6;
        wr0_en = 1; wr0_addr = 6; wr0_data = 32'h00000066;
        cyc();
        idle();
        rd_addr3 = 6; rd_use3 = 1;
        #1;
        check("setclr_busy6", busy_vec, 16'h0040);
        check("setclr_data6", rd_data3, 32'h00000066);
        check("setclr_stall", stall, 1'b1);
        idle();
        rd_addr3 = 0;

        // bypass on r9: old value 0x99, then busy, then write + read same cycle
        wr0_en = 1; wr0_addr = 9; wr0_data = 32'h00000099;
        cyc();
        idle();
        issue_en = 1; issue_dest = 9;
        cyc();
        idle();
        wr0_en = 1; wr0_addr = 9; wr0_data = 32'hCAFEF00D;
        rd_addr1 = 9; rd_use1 = 1;
        #1;
`ifdef RF_BYPASS_EN
        check("bypass_data", rd_data1, 32'hCAFEF00D);
        check("bypass_stall", stall, 1'b0);
`else
        check("nobypass_data", rd_data1, 32'h00000099);
        check("nobypass_stall", stall, 1'b1);
`endif
        cyc();
        idle();
        rd_use1 = 1;
        #1;
        check("post_wr_busy9", busy_vec[9], 1'b0);
        check("post_wr_data9", rd_data1, 32'hCAFEF00D);
        check("post_wr_stall", stall, 1'b0);

        // both ports writing the address being read
        wr0_en = 1; wr0_addr = 9; wr0_data = 32'h01010101;
        wr1_en = 1; wr1_addr = 9; wr1_data = 32'h02020202;
        #1;
`ifdef RF_BYPASS_EN
        check("bypass_conflict", rd_data1, 32'h02020202);
`else
        check("nobypass_conflict", rd_data1, 32'hCAFEF00D);
`endif
        cyc();
        idle();
        #1 check("conflict_r9", rd_data1, 32'h02020202);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
